// File: rtl/ctrl_regfile_param_if.sv
// Byte-wide SPI register access bus: write/read strobes, address and write data.
// The SPI slave drives it (master); the register file consumes it (slave).
interface ctrl_regfile_param_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic [DW-1:0] dout;
  logic [AW-1:0] index;
  logic          wr_en;
  logic          rd_en;

  modport master (output dout, output index, output wr_en, output rd_en);
  modport slave  (input  dout, input  index, input  wr_en, input  rd_en);
endinterface

// File: rtl/ctrl_regfile_param.sv
// Control/status register file: shadowed control regs with atomic commit, self-clearing
// command pulses and coherent multi-byte status snapshots. Optional lock: REG_LOCK_EN.
module ctrl_regfile_param #(
  parameter int                        DW        = 8,
  parameter int                        AW        = 4,
  parameter int                        NUM_CTRL  = 2,
  parameter int                        STAT_W    = 28,
  parameter int                        PULSE_LEN = 4,
  parameter logic [NUM_CTRL*DW-1:0]    CTRL_RST  = 16'h0008
) (
  input  logic                   spi_clk,
  input  logic                   rst_n,
  ctrl_regfile_param_if.slave    spi_if,
  input  logic [STAT_W-1:0]      status_in,
  output logic [DW-1:0]          read_data,
  output logic [NUM_CTRL*DW-1:0] ctrl_q,
  output logic [DW-1:0]          cmd_pulse,
  output logic                   commit_pulse
);

  localparam int STAT_BYTES = (STAT_W + DW - 1) / DW;
  localparam int CW         = $clog2(PULSE_LEN + 1);

  localparam logic [AW-1:0] CMD_IDX    = AW'(NUM_CTRL);
  localparam logic [AW-1:0] COMMIT_IDX = AW'(NUM_CTRL + 1);
  localparam logic [AW-1:0] STAT_IDX   = AW'(NUM_CTRL + 2);
  localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_LEN);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [DW-1:0]                shadow_r [NUM_CTRL];
  logic [NUM_CTRL*DW-1:0]       active_r;
  logic [DW-1:0]                cmd_r;
  logic [CW-1:0]                cnt_r;
  logic                         commit_r;
  logic [STAT_BYTES*DW-1:DW]    snap_r;
  logic [STAT_BYTES*DW-1:0]     stat_pad_s;
  logic [DW-1:0]                map_s [2**AW];
  logic                         lock_s;
  logic                         wr_shadow_s;
  logic                         wr_cmd_s;
  logic                         wr_commit_s;
  logic                         do_commit_s;
  logic                         snap_s;

  assign wr_shadow_s = spi_if.wr_en && (spi_if.index < CMD_IDX) && !lock_s;
  assign wr_cmd_s    = spi_if.wr_en && (spi_if.index == CMD_IDX);
  assign wr_commit_s = spi_if.wr_en && (spi_if.index == COMMIT_IDX);
  assign snap_s      = spi_if.rd_en && (spi_if.index == STAT_IDX);

`ifdef REG_LOCK_EN
  localparam logic [DW-1:0] UNLOCK_KEY = DW'(8'hA5);

  logic lock_r;
  logic unlock_s;

  assign unlock_s    = wr_commit_s && (spi_if.dout == UNLOCK_KEY);
  assign do_commit_s = wr_commit_s && !unlock_s && spi_if.dout[0] && !lock_r;
  assign lock_s      = lock_r;

  // Lock flop: the unlock key clears it, any other COMMIT write with the top bit set sets it.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r <= 1'b0;
    end else if (unlock_s) begin
      lock_r <= 1'b0;
    end else if (wr_commit_s && spi_if.dout[DW-1]) begin
      lock_r <= 1'b1;
    end
  end
`else
  assign do_commit_s = wr_commit_s && spi_if.dout[0];
  assign lock_s      = 1'b0;
`endif

  // Shadow capture, atomic commit of all shadows into the active bank, and the commit strobe.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        shadow_r[i] <= CTRL_RST[i*DW +: DW];
      end
      active_r <= CTRL_RST;
      commit_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (wr_shadow_s && (spi_if.index == AW'(i))) begin
          shadow_r[i] <= spi_if.dout;
        end
        if (do_commit_s) begin
          active_r[i*DW +: DW] <= shadow_r[i];
        end
      end
      commit_r <= do_commit_s;
    end
  end

  // Command pulses: a write ORs bits in and restarts the countdown; all bits drop together at 1->0.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r <= '0;
      cnt_r <= '0;
    end else if (wr_cmd_s) begin
      cmd_r <= cmd_r | spi_if.dout;
      cnt_r <= PULSE_LD;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_ONE;
      if (cnt_r == CNT_ONE) begin
        cmd_r <= '0;
      end
    end
  end

  // Reading status byte 0 freezes the upper bytes so a multi-byte read is coherent.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r <= '0;
    end else if (snap_s) begin
      snap_r <= stat_pad_s[STAT_BYTES*DW-1:DW];
    end
  end

  // Address map; unmapped addresses read zero.
  always_comb begin
    stat_pad_s              = '0;
    stat_pad_s[STAT_W-1:0]  = status_in;
    for (int a = 0; a < 2**AW; a++) begin
      map_s[a] = '0;
    end
    for (int i = 0; i < NUM_CTRL; i++) begin
      map_s[AW'(i)] = shadow_r[i];
    end
    map_s[CMD_IDX]    = cmd_r;
    map_s[COMMIT_IDX] = {lock_s, {(DW-1){1'b0}}};
    map_s[STAT_IDX]   = stat_pad_s[DW-1:0];
    for (int k = 1; k < STAT_BYTES; k++) begin
      map_s[STAT_IDX + AW'(k)] = snap_r[k*DW +: DW];
    end
  end

  assign read_data    = map_s[spi_if.index];
  assign ctrl_q       = active_r;
  assign cmd_pulse    = cmd_r;
  assign commit_pulse = commit_r;

endmodule

// File: tb/tb_ctrl_regfile_param.sv
// Scoreboard bench for ctrl_regfile_param: directed sequences plus random bus traffic,
// checked against a behavioural model of the register map. Honours REG_LOCK_EN if defined.
module tb_ctrl_regfile_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NC = 2;
  localparam int SW = 28;
  localparam int PL = 4;

  typedef struct {
    logic [7:0]  rd;
    logic [15:0] ctrl;
    logic [7:0]  cmd;
    logic        cp;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [SW-1:0] status_in;
  logic [DW-1:0] read_data;
  logic [15:0]   ctrl_q;
  logic [DW-1:0] cmd_pulse;
  logic          commit_pulse;

  exp_t sb_q[$];
  int   n_pass;
  int   n_total;

  // Behavioural model state
  logic [7:0]  m_shadow [NC];
  logic [7:0]  m_active [NC];
  logic [7:0]  m_cmd;
  int          m_rem;
  logic [27:0] m_snap;
  logic        m_lock;
  logic        m_cp;

  ctrl_regfile_param_if #(.DW(DW), .AW(AW)) spi_if ();

  ctrl_regfile_param #(
    .DW(DW), .AW(AW), .NUM_CTRL(NC), .STAT_W(SW), .PULSE_LEN(PL), .CTRL_RST(16'h0008)
  ) dut (
    .spi_clk      (clk),
    .rst_n        (rst_n),
    .spi_if       (spi_if),
    .status_in    (status_in),
    .read_data    (read_data),
    .ctrl_q       (ctrl_q),
    .cmd_pulse    (cmd_pulse),
    .commit_pulse (commit_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_shadow[0] = 8'h08; m_shadow[1] = 8'h00;
    m_active[0] = 8'h08; m_active[1] = 8'h00;
    m_cmd = 8'h00; m_rem = 0; m_snap = 28'h0; m_lock = 1'b0; m_cp = 1'b0;
  endfunction

  function automatic logic [7:0] model_read(input int idx, input logic [27:0] st);
    if (idx < NC)                 return m_shadow[idx];
    if (idx == NC)                return m_cmd;
    if (idx == NC + 1)            return {m_lock, 7'b0};
    if (idx == NC + 2)            return st[7:0];
    if (idx > NC + 2 && idx <= NC + 5) return 8'((m_snap >> (8 * (idx - NC - 2))) & 28'hFF);
    return 8'h00;
  endfunction

  function automatic void model_step(input bit wr, input bit rd, input int idx,
                                     input logic [7:0] d, input logic [27:0] st);
    bit commit = 1'b0;
    if (wr && idx < NC && !m_lock) m_shadow[idx] = d;
    if (wr && idx == NC) begin
      m_cmd = m_cmd | d;
      m_rem = PL;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_cmd = 8'h00;
    end
    if (wr && idx == NC + 1) begin
`ifdef REG_LOCK_EN
      if (d == 8'hA5) m_lock = 1'b0;
      else begin
        commit = d[0] && !m_lock;
        if (d[7]) m_lock = 1'b1;
      end
`else
      commit = d[0];
`endif
    end
    if (commit) for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
    m_cp = commit;
    if (rd && idx == NC + 2) m_snap = st;
  endfunction

  // One bus cycle: drive, queue expectation, advance the model across the clock edge.
  task automatic cycle(input bit wr, input bit rd, input int idx, input logic [7:0] d);
    exp_t e;
    spi_if.wr_en = wr; spi_if.rd_en = rd; spi_if.index = 4'(idx); spi_if.dout = d;
    e.rd = model_read(idx, status_in);
    e.ctrl = {m_active[1], m_active[0]};
    e.cmd = m_cmd;
    e.cp = m_cp;
    sb_q.push_back(e);
    @(posedge clk);
    if (rst_n) model_step(wr, rd, idx, d, status_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 15, 8'h00);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("read_data", 32'(read_data), 32'(e.rd));
        chk("ctrl_q", 32'(ctrl_q), 32'(e.ctrl));
        chk("cmd_pulse", 32'(cmd_pulse), 32'(e.cmd));
        chk("commit_pulse", 32'(commit_pulse), 32'(e.cp));
      end
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; status_in = '0;
    spi_if.wr_en = 1'b0; spi_if.rd_en = 1'b0; spi_if.index = '0; spi_if.dout = '0;
    model_reset();
    @(posedge clk); #1;
    idle(2);
    rst_n = 1'b1;

    cycle(1'b0, 1'b1, 0, 8'h00);
    cycle(1'b0, 1'b1, 1, 8'h00);

    // Shadow write is invisible on ctrl_q until commit
    cycle(1'b1, 1'b0, 0, 8'hF0);
    cycle(1'b0, 1'b1, 0, 8'h00);
    cycle(1'b1, 1'b0, 3, 8'h00);
    cycle(1'b1, 1'b0, 3, 8'h01);
    idle(3);

    // Command pulse extended by a second write
    cycle(1'b1, 1'b0, 2, 8'h20);
    idle(1);
    cycle(1'b1, 1'b0, 2, 8'h01);
    cycle(1'b0, 1'b1, 2, 8'h00);
    idle(5);
    cycle(1'b1, 1'b0, 2, 8'h04);
    cycle(1'b1, 1'b0, 2, 8'h00);
    idle(6);

    // Coherent status snapshot
    status_in = 28'hABCDEF1;
    cycle(1'b0, 1'b1, 4, 8'h00);
    status_in = 28'h0;
    cycle(1'b0, 1'b1, 5, 8'h00);
    cycle(1'b0, 1'b1, 6, 8'h00);
    cycle(1'b0, 1'b1, 7, 8'h00);
    cycle(1'b0, 1'b1, 8, 8'h00);
    cycle(1'b1, 1'b1, 9, 8'hFF);

    // Lock sequence (A5 commits when lock is not built in)
    cycle(1'b1, 1'b0, 3, 8'h80);
    cycle(1'b1, 1'b0, 0, 8'h55);
    cycle(1'b1, 1'b0, 3, 8'h01);
    cycle(1'b0, 1'b1, 3, 8'h00);
    cycle(1'b1, 1'b0, 3, 8'hA5);
    cycle(1'b1, 1'b0, 1, 8'h77);
    cycle(1'b1, 1'b0, 3, 8'h01);
    cycle(1'b0, 1'b1, 3, 8'h00);
    idle(2);

    // Reset mid-pulse with a pending snapshot
    status_in = 28'h1234567;
    cycle(1'b1, 1'b0, 2, 8'h0F);
    cycle(1'b0, 1'b1, 4, 8'h00);
    async_reset();
    cycle(1'b0, 1'b1, 5, 8'h00);
    cycle(1'b0, 1'b1, 0, 8'h00);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit wr, rd;
      int idx;
      logic [7:0] d;
      wr  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 1) == 0);
      idx = (n % 5 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: d = 8'hA5;
        1: d = 8'h01;
        2: d = 8'h81;
        default: d = 8'($urandom);
      endcase
      status_in = 28'($urandom);
      if (n == 300) async_reset();
      cycle(wr, rd, idx, d);
    end
    idle(1);

    repeat (2) @(negedge clk);
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
